mult_div_unit: RTL and testbench

- Multiply/divide unit in the EX stage; consumes the E-stage mul/div control fields and forwarded operands.
- Owns the architectural HI/LO registers.
- Models fixed multi-cycle latency and raises a stall request to the hazard unit while a result is pending.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mdu_arith.sv | 61 ++++++
 rtl/mult_div_unit.sv | 102 ++++++++++
 tb/tb_mult_div_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: word width, mul_op and HI/LO select codes, FSM states.
package mult_div_unit_pkg;

  localparam int WORD = 32;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MADD  = 3'd5;
  localparam logic [2:0] OP_MADDU = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  localparam logic [1:0] HILO_HI = 2'b01;
  localparam logic [1:0] HILO_LO = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mduStateE;

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mul/div (and madd/maddu/msub when MDU_MADD_EN is defined).
// Result layout is {hi, lo}; divides put the remainder in hi and the quotient in lo.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [WORD-1:0]   srcA,
  input  logic [WORD-1:0]   srcB,
  input  logic [WORD-1:0]   hiIn,
  input  logic [WORD-1:0]   loIn,
  output logic [2*WORD-1:0] result
);

  logic signed [2*WORD-1:0] sProd;
  logic [2*WORD-1:0]        uProd;
  logic signed [WORD-1:0]   sQuo;
  logic signed [WORD-1:0]   sRem;
  logic [WORD-1:0]          uQuo;
  logic [WORD-1:0]          uRem;
  logic                     divZero;
  logic                     divOvf;

  assign sProd   = $signed({{WORD{srcA[WORD-1]}}, srcA}) * $signed({{WORD{srcB[WORD-1]}}, srcB});
  assign uProd   = {{WORD{1'b0}}, srcA} * {{WORD{1'b0}}, srcB};
  assign sQuo    = $signed(srcA) / $signed(srcB);
  assign sRem    = $signed(srcA) % $signed(srcB);
  assign uQuo    = srcA / srcB;
  assign uRem    = srcA % srcB;
  assign divZero = (srcB == '0);
  // The only signed quotient that does not fit in a word.
  assign divOvf  = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

`ifndef MDU_MADD_EN
  logic unusedAcc;
  assign unusedAcc = ^{hiIn, loIn};
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_MULT:  result = sProd;
      OP_MULTU: result = uProd;
      OP_DIV: begin
        if (divZero)     result = {srcA, 32'hFFFF_FFFF};
        else if (divOvf) result = {32'h0000_0000, 32'h8000_0000};
        else             result = {sRem, sQuo};
      end
      OP_DIVU: begin
        if (divZero) result = {srcA, 32'hFFFF_FFFF};
        else         result = {uRem, uQuo};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hiIn, loIn} + sProd;
      OP_MADDU: result = {hiIn, loIn} + uProd;
      OP_MSUB:  result = {hiIn, loIn} - sProd;
`endif
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, models fixed latency and requests stalls while busy.
// Optional accumulate ops (madd/maddu/msub) are enabled by defining MDU_MADD_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      mul_op,
  input  logic [1:0]      mthilo,
  input  logic [1:0]      mfhilo,
  input  logic [WORD-1:0] src_a,
  input  logic [WORD-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic [WORD-1:0] hi,
  output logic [WORD-1:0] lo,
  output logic [WORD-1:0] hilo_rd,
  output mduStateE        dbgState
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  mduStateE          state;
  mduStateE          nextState;
  logic [CW-1:0]     count;
  logic [2*WORD-1:0] pending;
  logic [2*WORD-1:0] arithResult;
  logic              opValid;
  logic              startOp;
  logic              mtEn;
  logic              lastCycle;

  mdu_arith uArith (
    .op     (mul_op),
    .srcA   (src_a),
    .srcB   (src_b),
    .hiIn   (hi),
    .loIn   (lo),
    .result (arithResult)
  );

`ifdef MDU_MADD_EN
  assign opValid = (mul_op != OP_NONE);
`else
  // Reserved accumulate encodings neither start nor stall.
  assign opValid = (mul_op != OP_NONE) && (mul_op <= OP_DIVU);
`endif

  assign startOp   = opValid && !flush && (state == S_IDLE);
  assign mtEn      = (state == S_IDLE) && !flush && !startOp;
  assign lastCycle = (state == S_RUN) && (count == CW'(1));
  assign busy      = (state == S_RUN);
  assign stall     = busy || (opValid && !flush);
  assign dbgState  = state;

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (startOp) nextState = S_RUN;
      S_RUN:   if (lastCycle) nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= nextState;
      if (startOp) begin
        pending <= arithResult;
        count   <= isDivOp(mul_op) ? DIV_LOAD : MULT_LOAD;
      end else if (state == S_RUN) begin
        count <= count - CW'(1);
        if (lastCycle) {hi, lo} <= pending;
      end
      if (mtEn && (mthilo == HILO_HI)) hi <= src_a;
      if (mtEn && (mthilo == HILO_LO)) lo <= src_a;
    end
  end

  always_comb begin
    hilo_rd = '0;
    case (mfhilo)
      HILO_HI: hilo_rd = hi;
      HILO_LO: hilo_rd = lo;
      default: hilo_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal checks plus randomized traffic against a behavioural HI/LO model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mul_op = '0;
  logic [1:0]  mthilo = '0;
  logic [1:0]  mfhilo = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_rd;
  mduStateE    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: architectural HI/LO, cycles left before commit, queued results.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_rem = 0;
  logic [63:0] exp_q[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .mul_op   (mul_op),
    .mthilo   (mthilo),
    .mfhilo   (mfhilo),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .hilo_rd  (hilo_rd),
    .dbgState (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_valid(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return op != 3'd0;
`else
    return (op >= 3'd1) && (op <= 3'd4);
`endif
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          q;
    longint          r;
    case (op)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;   // 64-bit arithmetic: -2^31 / -1 gives 2^31, which truncates to 0x80000000
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd5: return acc + 64'(sa * sb);
      3'd6: return acc + 64'(ua * ub);
      3'd7: return acc - 64'(sa * sb);
      default: return 64'd0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    logic [63:0] res;
    if (reset) begin
      m_hi  = '0;
      m_lo  = '0;
      m_rem = 0;
      exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        res = exp_q.pop_front();
        {m_hi, m_lo} = res;
      end
    end else if (op_valid(mul_op) && !flush) begin
      exp_q.push_back(ref_result(mul_op, src_a, src_b, {m_hi, m_lo}));
      m_rem = (mul_op == 3'd3 || mul_op == 3'd4) ? 10 : 5;
    end else if (!flush) begin
      if (mthilo == 2'b01) m_hi = src_a;
      if (mthilo == 2'b10) m_lo = src_a;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic        e_busy;
    logic [31:0] e_rd;
    if (chk_en) begin
      e_busy = (m_rem > 0);
      e_rd   = (mfhilo == 2'b01) ? m_hi : (mfhilo == 2'b10) ? m_lo : 32'h0;
      check("busy", {31'b0, busy}, {31'b0, e_busy});
      check("stall", {31'b0, stall}, {31'b0, e_busy | (op_valid(mul_op) & !flush)});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("hilo_rd", hilo_rd, e_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] mt, input logic [1:0] mf,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    mul_op = op;
    mthilo = mt;
    mfhilo = mf;
    src_a  = a;
    src_b  = b;
    flush  = fl;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_cycles, input string name);
    int n;
    drive(op, 2'b00, 2'b00, a, b, 1'b0);
    tick();
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    wait_idle(n);
    check(name, n, exp_cycles);
    tick();
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5, "mult_busy_cycles");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 5, "multu_busy_cycles");
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, "div_busy_cycles");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd0, 10, "divu0_busy_cycles");
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0007);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf_busy_cycles");
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    // flushed start and flushed MT write
    drive(3'd1, 2'b00, 2'b00, 32'd5, 32'd5, 1'b1);
    #1;
    check("flush_stall", {31'b0, stall}, 32'h0);
    tick();
    drive(3'd0, 2'b01, 2'b00, 32'hAAAA_5555, 32'h0, 1'b1);
    check("flush_busy", {31'b0, busy}, 32'h0);
    tick();
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    check("flush_hi", hi, 32'h0);
    check("flush_lo", lo, 32'h8000_0000);

    // MTHI then MFHI
    drive(3'd0, 2'b01, 2'b00, 32'h1234_5678, 32'h0, 1'b0);
    tick();
    drive(3'd0, 2'b00, 2'b01, 32'h0, 32'h0, 1'b0);
    #1;
    check("mfhi_rd", hilo_rd, 32'h1234_5678);
    tick();

    // MTLO while busy is ignored; result commits
    drive(3'd1, 2'b00, 2'b00, 32'd3, 32'd4, 1'b0);
    tick();
    drive(3'd0, 2'b10, 2'b00, 32'hDEAD_BEEF, 32'h0, 1'b0);
    tick();
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    check("mt_busy_lo", lo, 32'h8000_0000);
    wait_idle(n);
    tick();
    check("mt_busy_final_lo", lo, 32'd12);
    check("mt_busy_final_hi", hi, 32'd0);

    // reset during the 4th busy cycle of a divide
    drive(3'd3, 2'b00, 2'b00, 32'd100, 32'd3, 1'b0);
    tick();
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    repeat (12) tick();
    check("rst_late_hi", hi, 32'h0);
    check("rst_late_lo", lo, 32'h0);

`ifdef MDU_MADD_EN
    drive(3'd0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    drive(3'd0, 2'b10, 2'b00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    tick();
    run_op(3'd5, 32'd1, 32'd1, 5, "madd_busy_cycles");
    check("madd_hi", hi, 32'h1);
    check("madd_lo", lo, 32'h0);
    run_op(3'd7, 32'd2, 32'd1, 5, "msub_busy_cycles");
    check("msub_hi", hi, 32'h0);
    check("msub_lo", lo, 32'hFFFF_FFFE);
`else
    drive(3'd5, 2'b00, 2'b00, 32'd1, 32'd1, 1'b0);
    #1;
    check("reserved_stall", {31'b0, stall}, 32'h0);
    tick();
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    check("reserved_busy", {31'b0, busy}, 32'h0);
`endif

    // randomized traffic, checked cycle by cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            rand_word(), rand_word(), ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    drive(3'd0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    repeat (12) tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
